// File: rtl/mms_pkg.sv
// Shared definitions for the 8-number max/min loader and its selector.
package mms_pkg;

  localparam int MMS_WIDTH = 8;
  localparam int MMS_N_NUM = 8;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mms_8num_loader.sv
// Sequential loader around the combinational 8-number max/min selector.
// Collects 8 numbers over a valid/ready stream, presents them on a flat bus,
// registers the selector's answer and returns it over a valid/ready output.
// Optional build macro MMS_OVERLAP_EN: lets the next group load while a
// result is still waiting in DONE.
module mms_8num_loader
  import mms_pkg::*;
#(
  parameter int WIDTH = MMS_WIDTH,
  parameter int N_NUM = MMS_N_NUM
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_number,
  input  logic                   in_select,
  output logic [N_NUM*WIDTH-1:0] mms_number,
  output logic                   mms_select,
  input  logic [WIDTH-1:0]       mms_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       result,
  output logic                   out_select
);

  localparam int CNT_W = $clog2(N_NUM);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_NUM - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] slot [N_NUM];

  logic in_fire;
  logic out_fire;
  logic last_fire;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_fire = in_fire && (cnt == LAST);

  // Flatten the slot file onto the selector bus, number k at [k*WIDTH +: WIDTH].
  for (genvar k = 0; k < N_NUM; k++) begin : g_flat
    assign mms_number[k*WIDTH +: WIDTH] = slot[k];
  end

`ifdef MMS_OVERLAP_EN
  // Next group fully loaded while the previous result still waits.
  logic full_q;

  // Track the FULL-pending condition; an output transfer always consumes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
    end else if (out_fire) begin
      full_q <= 1'b0;
    end else if (state_q == DONE && last_fire) begin
      full_q <= 1'b1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: if (last_fire) state_d = CALC;
      CALC: state_d = DONE;
      DONE: begin
`ifdef MMS_OVERLAP_EN
        if (out_fire) state_d = (full_q || last_fire) ? CALC : LOAD;
`else
        if (out_fire) state_d = LOAD;
`endif
      end
      default: state_d = LOAD;
    endcase
  end

  // Handshake outputs decoded from state; reset holds off new input.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      LOAD: in_ready = !reset;
      DONE: begin
        out_valid = 1'b1;
`ifdef MMS_OVERLAP_EN
        in_ready  = !reset && !full_q;
`endif
      end
      default: ;
    endcase
  end

  // Slot file, count and group select: written on every accepted number.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      mms_select <= 1'b0;
      for (int k = 0; k < N_NUM; k++) slot[k] <= '0;
    end else if (in_fire) begin
      slot[cnt] <= in_number;
      cnt       <= cnt + 1'b1;
      if (cnt == '0) mms_select <= in_select;
    end
  end

  // Result capture during the single CALC cycle; held through DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      result     <= '0;
      out_select <= 1'b0;
    end else if (state_q == CALC) begin
      result     <= mms_result;
      out_select <= mms_select;
    end
  end

endmodule
